// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sharing arbiter.
package alu_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned OP_W_DEF   = 4;

    // Operation codes as produced by the ALU controller; passed through untouched.
    typedef enum logic [3:0] {
        OpAnd  = 4'b0000,
        OpOr   = 4'b0001,
        OpAdd  = 4'b0010,
        OpSub  = 4'b0011,
        OpSll  = 4'b0100,
        OpSlt  = 4'b0101,
        OpXor  = 4'b0110,
        OpSrl  = 4'b0111,
        OpSra  = 4'b1000,
        OpNor  = 4'b1001,
        OpBeq  = 4'b1010,
        OpBne  = 4'b1011,
        OpSltu = 4'b1100
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } arb_state_t;

    // A requester may take the ALU unless the other one is also asking and
    // it was not the other one that was served last.
    function automatic logic rr_may_win(logic other_valid, logic other_was_last);
        return ~other_valid | other_was_last;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; owns the last-grant pointer.
module rr_arbiter2
    import alu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    input  logic adv_grant,
    output logic avail0,
    output logic avail1
);

    logic last_q;

    // Each avail depends only on the other requester, so a ready never
    // waits on its own valid.
    always_comb begin
        avail0 = rr_may_win(req1, last_q);
        avail1 = rr_may_win(req0, ~last_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= adv_grant;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Optional grant counters are enabled by defining ALU_SHARE_GRANT_STATS_EN.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
`ifdef ALU_SHARE_GRANT_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);

    arb_state_t        state_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic              grant_q;
    logic [1:0]        rsp_valid_q;

    logic avail0;
    logic avail1;
    logic idle;
    logic acc0;
    logic acc1;
    logic accept;
    logic rsp_ready_g;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0_valid),
        .req1      (req1_valid),
        .advance   (accept),
        .adv_grant (acc1),
        .avail0    (avail0),
        .avail1    (avail1)
    );

    always_comb begin
        idle        = (state_q == StIdle) && !reset;
        req0_ready  = idle && avail0;
        req1_ready  = idle && avail1;
        acc0        = req0_valid && req0_ready;
        acc1        = req1_valid && req1_ready;
        accept      = acc0 || acc1;
        rsp_ready_g = grant_q ? rsp1_ready : rsp0_ready;
    end

    // The ALU only ever sees registered operands, never live requester inputs.
    assign alu_op      = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;

    assign rsp0_valid  = rsp_valid_q[0] && !reset;
    assign rsp1_valid  = rsp_valid_q[1] && !reset;
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            grant_q     <= 1'b0;
            rsp_valid_q <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q    <= acc1 ? req1_op : req0_op;
                        a_q     <= acc1 ? req1_a  : req0_a;
                        b_q     <= acc1 ? req1_b  : req0_b;
                        grant_q <= acc1;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    res_q       <= alu_result;
                    zero_q      <= alu_zero;
                    rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready_g) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_GRANT_STATS_EN
    logic [15:0] grant_cnt0_q;
    logic [15:0] grant_cnt1_q;

    // Saturating accept counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            if (acc0 && grant_cnt0_q != 16'hFFFF) begin
                grant_cnt0_q <= grant_cnt0_q + 16'd1;
            end
            if (acc1 && grant_cnt1_q != 16'hFFFF) begin
                grant_cnt1_q <= grant_cnt1_q + 16'd1;
            end
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised scoreboard bench for alu_share_arbiter with a behavioural ALU and arbiter model.
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_zero;
`ifdef ALU_SHARE_GRANT_STATS_EN
    logic [15:0]  grant_cnt0, grant_cnt1;
`endif

    // Requester-side stimulus state, indexed by port.
    logic         pv[2];
    logic [3:0]   pop[2];
    logic [W-1:0] pa[2];
    logic [W-1:0] pb[2];
    logic         prr[2];
    int           mode[2];   // 0 off, 1 hold fixed, 2 one-shot fixed, 3 random, 4 manual
    logic [3:0]   fop[2];
    logic [W-1:0] fa[2];
    logic [W-1:0] fb[2];
    int           rmode[2];  // 0 fixed rfix, 1 random
    logic         rfix[2];
    logic         s_acc[2];

    assign req0_valid = pv[0];
    assign req0_op    = pop[0];
    assign req0_a     = pa[0];
    assign req0_b     = pb[0];
    assign req1_valid = pv[1];
    assign req1_op    = pop[1];
    assign req1_a     = pa[1];
    assign req1_b     = pb[1];
    assign rsp0_ready = prr[0];
    assign rsp1_ready = prr[1];

    alu_share_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp0_zero   (rsp0_zero),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .rsp1_zero   (rsp1_zero),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
`ifdef ALU_SHARE_GRANT_STATS_EN
        ,
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
`endif
    );

    // Behavioural ALU: {zero, result}.
    function automatic logic [W:0] alu_f(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] r;
        logic         z;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd3:    r = a - b;
            4'd4:    r = a << b[4:0];
            4'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    r = a ^ b;
            4'd7:    r = a >> b[4:0];
            4'd8:    r = $unsigned($signed(a) >>> b[4:0]);
            4'd9:    r = ~(a | b);
            4'd10:   r = a - b;
            4'd11:   r = a - b;
            4'd12:   r = (a < b) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        if (op == 4'd10)      z = (a == b);
        else if (op == 4'd11) z = (a != b);
        else                  z = (r == '0);
        return {z, r};
    endfunction

    always_comb {alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);

    int passes = 0;
    int total  = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic         port;
        logic [W-1:0] res;
        logic         z;
    } exp_t;

    exp_t        sb[$];
    logic        busy = 1'b0;
    logic        owner = 1'b0;
    int          age = 0;
    logic        last_m = 1'b1;
    logic        hold = 1'b0;
    logic [W-1:0] hold_res;
    logic        hold_z;
    longint      cnt_m[2];

    always @(negedge clk) begin
        logic         v0, v1, a0, a1, win, exp_win;
        logic [W:0]   rz;
        logic [1:0]   exp_v;
        exp_t         e;
        logic         rv, rr_g;
        logic [W-1:0] rres;
        logic         rzz;
        v0 = req0_valid; v1 = req1_valid;
        a0 = v0 && req0_ready; a1 = v1 && req1_ready;
        if (reset) begin
            chk("reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 4'b0000);
            sb.delete();
            busy = 1'b0; age = 0; last_m = 1'b1; hold = 1'b0;
            cnt_m[0] = 0; cnt_m[1] = 0;
        end else if (!busy) begin
            chk("idle_some_ready", req0_ready | req1_ready, 1'b1);
            chk("idle_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
            chk("idle_accept", {a0 & a1, a0 | a1}, {1'b0, v0 | v1});
            if (a0 || a1) begin
                win = a1;
                exp_win = (v0 && v1) ? ~last_m : v1;
                chk("rr_pick", win, exp_win);
                rz = win ? alu_f(req1_op, req1_a, req1_b) : alu_f(req0_op, req0_a, req0_b);
                e.port = win; e.res = rz[W-1:0]; e.z = rz[W];
                sb.push_back(e);
                last_m = win; owner = win; busy = 1'b1; age = 0;
                cnt_m[win] = cnt_m[win] + 1;
            end
        end else begin
            age++;
            chk("busy_no_ready", req0_ready | req1_ready, 1'b0);
            exp_v = (age >= 2) ? (owner ? 2'b10 : 2'b01) : 2'b00;
            chk("rsp_valid_timing", {rsp1_valid, rsp0_valid}, exp_v);
            rv   = owner ? rsp1_valid : rsp0_valid;
            rr_g = owner ? rsp1_ready : rsp0_ready;
            rres = owner ? rsp1_result : rsp0_result;
            rzz  = owner ? rsp1_zero : rsp0_zero;
            if (hold) chk("rsp_hold_stable", {rzz, rres}, {hold_z, hold_res});
            if (rv) begin
                if (rr_g) begin
                    if (sb.size() == 0) begin
                        chk("scoreboard_nonempty", 1'b0, 1'b1);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_port", owner, e.port);
                        chk("rsp_result", rres, e.res);
                        chk("rsp_zero", rzz, e.z);
                    end
                    busy = 1'b0; hold = 1'b0;
                end else begin
                    hold = 1'b1; hold_res = rres; hold_z = rzz;
                end
            end
        end
    end

    // ---------------- requester driver ----------------
    task automatic step(int p);
        case (mode[p])
            0: pv[p] = 1'b0;
            1: begin pv[p] = 1'b1; pop[p] = fop[p]; pa[p] = fa[p]; pb[p] = fb[p]; end
            2: begin
                if (s_acc[p]) begin
                    pv[p] = 1'b0; mode[p] = 0;
                end else begin
                    pv[p] = 1'b1; pop[p] = fop[p]; pa[p] = fa[p]; pb[p] = fb[p];
                end
            end
            3: begin
                if (pv[p] && !s_acc[p]) begin
                    if ($urandom_range(0, 5) == 0) pv[p] = 1'b0;
                end else begin
                    pv[p]  = ($urandom_range(0, 2) != 0);
                    pop[p] = 4'($urandom_range(0, 12));
                    pa[p]  = $urandom;
                    pb[p]  = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom;
                end
            end
            default: ;
        endcase
        if (rmode[p] == 1) prr[p] = ($urandom_range(0, 9) < 7);
        else               prr[p] = rfix[p];
    endtask

    initial begin
        forever begin
            @(negedge clk);
            s_acc[0] = pv[0] && req0_ready;
            s_acc[1] = pv[1] && req1_ready;
            @(posedge clk);
            #1;
            step(0);
            step(1);
        end
    end

    task automatic wait_rsp(int p, int bound);
        int n = 0;
        while (((p == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) chk("wait_rsp_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain(int bound);
        int n = 0;
        mode[0] = 0; mode[1] = 0;
        rmode[0] = 0; rmode[1] = 0; rfix[0] = 1'b1; rfix[1] = 1'b1;
        while ((busy || sb.size() != 0 || pv[0] || pv[1]) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) chk("drain_timeout", 1'b0, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", passes, total);
        $fatal(1);
    end

    initial begin
        int n;
        for (int p = 0; p < 2; p++) begin
            pv[p] = 0; pop[p] = 0; pa[p] = 0; pb[p] = 0; prr[p] = 1;
            mode[p] = 0; rmode[p] = 0; rfix[p] = 1; s_acc[p] = 0;
            fop[p] = 0; fa[p] = 0; fb[p] = 0;
        end
        // Single req0 ADD 5+7 straight out of reset.
        mode[0] = 2; fop[0] = 4'b0010; fa[0] = 32'd5; fb[0] = 32'd7;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("first_ready0", {req0_valid, req0_ready}, 2'b11);
        wait_rsp(0, 10);
        chk("add_result", rsp0_result, 32'd12);
        chk("add_zero", rsp0_zero, 1'b0);
        chk("add_rsp1_quiet", rsp1_valid, 1'b0);
        drain(50);

        // Both hold requests: grants must alternate.
        fop[0] = 4'b0011; fa[0] = 32'd9; fb[0] = 32'd9;
        fop[1] = 4'b0010; fa[1] = 32'd1; fb[1] = 32'd1;
        mode[0] = 1; mode[1] = 1;
        wait_rsp(0, 20);
        chk("sub_result", rsp0_result, 32'd0);
        chk("sub_zero", rsp0_zero, 1'b1);
        wait_rsp(1, 20);
        chk("add11_result", rsp1_result, 32'd2);
        repeat (16) @(negedge clk);
        drain(50);

        // Back-pressured response on port 1.
        rfix[1] = 1'b0;
        fop[1] = 4'b0010; fa[1] = 32'd3; fb[1] = 32'd4;
        mode[1] = 2;
        wait_rsp(1, 20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_rsp1", {rsp1_valid, rsp1_result}, {1'b1, 32'd7});
        end
        rfix[1] = 1'b1;
        drain(50);

        // Reset while req0 is in EXEC, then a simultaneous request pair.
        fop[0] = 4'b0110; fa[0] = 32'hF0F0; fb[0] = 32'h0FF0;
        mode[0] = 2;
        n = 0;
        while (!(req0_valid && req0_ready) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("exec_reset_accept", 1'b0, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        fop[0] = 4'b0001; fa[0] = 32'd1; fb[0] = 32'd2;
        fop[1] = 4'b0000; fa[1] = 32'd3; fb[1] = 32'd6;
        mode[0] = 2; mode[1] = 2;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_tie", {req0_ready, req1_ready}, 2'b10);
        drain(60);

        // req1 appears and drops while req0 holds the ALU.
        rfix[0] = 1'b0;
        fop[0] = 4'b0111; fa[0] = 32'h8000_0000; fb[0] = 32'd4;
        mode[0] = 2;
        wait_rsp(0, 20);
        mode[1] = 4;
        @(posedge clk); #1; pv[1] = 1'b1; pop[1] = 4'b0010; pa[1] = 32'd8; pb[1] = 32'd8;
        @(posedge clk); @(posedge clk); #1; pv[1] = 1'b0;
        rfix[0] = 1'b1;
        drain(50);

        // Randomised traffic.
        mode[0] = 3; mode[1] = 3; rmode[0] = 1; rmode[1] = 1;
        repeat (4000) @(negedge clk);
        drain(100);

`ifdef ALU_SHARE_GRANT_STATS_EN
        chk("cnt0_count", grant_cnt0, 16'(cnt_m[0]));
        chk("cnt1_count", grant_cnt1, 16'(cnt_m[1]));
        dut.grant_cnt0_q = 16'hFFFD;
        cnt_m[0] = 64'hFFFD;
        for (int i = 0; i < 4; i++) begin
            fop[0] = 4'b0010; fa[0] = i; fb[0] = 1;
            mode[0] = 2;
            drain(50);
        end
        chk("cnt0_saturated", grant_cnt0, (cnt_m[0] > 64'hFFFF) ? 16'hFFFF : 16'(cnt_m[0]));
        chk("cnt0_is_max", grant_cnt0, 16'hFFFF);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("cnt_cleared", {grant_cnt0, grant_cnt1}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
